// File: rtl/vec_instr_encoder.sv
// vec_instr_encoder: encodes field-level vector ops into 32-bit words, buffers them in a FIFO
// and issues them downstream, stalling reads of the most recently written vector register.
module vec_instr_encoder #(
  parameter int DEPTH   = 4,
  parameter int HAZ_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [2:0]               op_class,
  input  logic [1:0]               op_variant,
  input  logic                     op_scalar,
  input  logic [4:0]               vd,
  input  logic [4:0]               vs1,
  input  logic [4:0]               vs2,
  output logic [31:0]              instruction,
  output logic                     instruction_valid,
  input  logic                     instruction_ready,
  output logic                     illegal,
  output logic [7:0]               illegal_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    hz_cnt;
  logic [4:0]    hz_reg;
  logic [4:0]    opcode;
  logic          legal, enq_fire, push, pop, stall, head_wr;
  logic [31:0]   head;

  always_comb begin
    opcode = '0;
    legal  = 1'b1;
    case (op_class)
      3'd0: begin
        opcode = {4'b0000, op_variant[0]};
        legal  = !op_scalar && !op_variant[1];
      end
      3'd1: begin
        opcode = op_scalar ? 5'b00110 : {4'b0001, op_variant[0]};
        legal  = !(op_scalar && op_variant != 2'd0);
      end
      3'd2: opcode = {4'b0010, op_scalar};
      3'd3: begin
        opcode = op_variant[0] ? 5'b10000 : 5'b00111;
        legal  = !op_scalar && !op_variant[1];
      end
      3'd4: begin
        opcode = 5'b01000;
        legal  = !op_scalar && !op_variant[1];
      end
      3'd5: begin
        opcode = 5'd9 + 5'(op_variant);
        legal  = !op_scalar && op_variant != 2'd3;
      end
      3'd6: begin
        opcode = {3'b011, op_variant};
        legal  = !op_scalar;
      end
      default: legal = 1'b0;
    endcase
  end

  assign head      = mem[rd_ptr];
  assign enq_ready = fifo_count != CW'(DEPTH);
  assign enq_fire  = enq_valid && enq_ready;
  assign push      = enq_fire && legal && !flush;
  // VSTORE reads vd as a source; predicates and VSTORE never write a vector register
  assign head_wr   = head[31:27] != 5'd1 && (head[31:27] < 5'd12 || head[31:27] == 5'd16);
  assign stall     = hz_cnt != 4'd0 && (head[20:16] == hz_reg || head[15:11] == hz_reg ||
                     (head[31:27] == 5'd1 && head[25:21] == hz_reg));
  assign instruction_valid = fifo_count != '0 && !stall;
  assign instruction       = instruction_valid ? head : 32'd0;
  assign pop               = instruction_valid && instruction_ready;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {opcode, 1'b0, vd, vs1, vs2, 11'd0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      hz_cnt        <= '0;
      hz_reg        <= '0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      wr_ptr     <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr     <= flush ? '0 : rd_ptr + AW'(pop);
      fifo_count <= flush ? '0 : fifo_count + CW'(push) - CW'(pop);
      hz_cnt     <= flush ? '0 : (pop && head_wr) ? 4'(HAZ_LAT) : hz_cnt - 4'(hz_cnt != 4'd0);
      if (pop && head_wr) hz_reg <= head[25:21];
      illegal <= enq_fire && !legal;
      if (enq_fire && !legal && illegal_count != 8'hff) illegal_count <= illegal_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_vec_instr_encoder.sv
// tb_vec_instr_encoder: directed scenarios plus a randomized run against a queue/timestamp model.
module tb_vec_instr_encoder;
  localparam int DEPTH   = 4;
  localparam int HAZ_LAT = 3;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, reset = 1'b1, flush = 1'b0, enq_valid = 1'b0, enq_ready;
  logic [2:0]    op_class = '0;
  logic [1:0]    op_variant = '0;
  logic          op_scalar = 1'b0;
  logic [4:0]    vd = '0, vs1 = '0, vs2 = '0;
  logic [31:0]   instruction;
  logic          instruction_valid, instruction_ready = 1'b0, illegal;
  logic [7:0]    illegal_count;
  logic [CW-1:0] fifo_count;
  int            n_cmp = 0, n_bad = 0;

  vec_instr_encoder #(.DEPTH(DEPTH), .HAZ_LAT(HAZ_LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .op_class(op_class), .op_variant(op_variant), .op_scalar(op_scalar),
    .vd(vd), .vs1(vs1), .vs2(vs2), .instruction(instruction),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .illegal(illegal), .illegal_count(illegal_count), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [4:0] op, input logic [4:0] d, a, b);
    return {op, 1'b0, d, a, b, 11'd0};
  endfunction

  // returns {legal, opcode} from the mnemonic table
  function automatic logic [5:0] ref_enc(input logic [2:0] c, input logic [1:0] v, input logic s);
    logic ok;
    logic [4:0] op;
    ok = !(c == 7) && !(s && !(c == 1 && v == 0) && c != 2) &&
         !((c == 0 || c == 3 || c == 4) && v >= 2) && !(c == 5 && v == 3);
    case (c)
      0: op = v[0] ? 5'd1 : 5'd0;
      1: op = s ? 5'd6 : (v[0] ? 5'd3 : 5'd2);
      2: op = s ? 5'd5 : 5'd4;
      3: op = v[0] ? 5'd16 : 5'd7;
      4: op = 5'd8;
      5: op = 5'(9 + v);
      6: op = 5'(12 + v);
      default: op = 5'd0;
    endcase
    return {ok, op};
  endfunction

  function automatic bit writer(input logic [4:0] op);
    return !(op == 1 || (op >= 12 && op <= 15));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    enq_valid = 1'b0;
    flush = 1'b0;
    instruction_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] c, input logic [1:0] v, input logic s,
                         input logic [4:0] d, a, b);
    op_class = c; op_variant = v; op_scalar = s; vd = d; vs1 = a; vs2 = b;
  endtask

  task automatic enq(input logic [2:0] c, input logic [1:0] v, input logic s,
                     input logic [4:0] d, a, b);
    set_req(c, v, s, d, a, b);
    enq_valid = 1'b1;
    for (int i = 0; i < 50 && !enq_ready; i++) tick;
    n_cmp++;
    if (enq_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL enq_timeout: enq_ready=%b required 1", enq_ready);
    end
    tick;
    enq_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_dut;
    @(negedge clk);
    n_cmp += 6;
    if (instruction_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instruction_valid); end
    if (instruction !== 32'd0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instruction); end
    if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL rst_enq_ready: got %b want 1", enq_ready); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    if (illegal_count !== 8'd0) begin n_bad++; $display("FAIL rst_ill_cnt: got %0d want 0", illegal_count); end
  endtask

  task automatic test_vadd;
    reset_dut;
    instruction_ready = 1'b1;
    enq(1, 0, 0, 3, 1, 2);
    @(negedge clk);
    n_cmp += 2;
    if (instruction_valid !== 1'b1) begin n_bad++; $display("FAIL vadd_valid: got %b want 1", instruction_valid); end
    if (instruction !== 32'h10611000) begin n_bad++; $display("FAIL vadd_word: got %h want 10611000", instruction); end
    tick;
    @(negedge clk);
    n_cmp += 2;
    if (dut.hz_cnt !== 4'd3) begin n_bad++; $display("FAIL vadd_hz_cnt: got %0d want 3", dut.hz_cnt); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL vadd_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_hazard(input logic [4:0] mul_vs1, input int gap);
    int t_add, t_mul;
    logic [31:0] w_mul;
    t_add = -1;
    t_mul = -1;
    w_mul = word(5'd4, 5'd4, mul_vs1, 5'd5);
    reset_dut;
    enq(1, 0, 0, 3, 1, 2);
    enq(2, 0, 0, 4, mul_vs1, 5);
    instruction_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (instruction_valid && instruction == 32'h10611000) t_add = i;
      if (instruction_valid && instruction == w_mul) t_mul = i;
      tick;
    end
    n_cmp += 2;
    if (t_add != 0) begin n_bad++; $display("FAIL hz_add_issue: cycle %0d want 0", t_add); end
    if (t_mul - t_add != gap) begin n_bad++; $display("FAIL hz_gap_vs1_%0d: gap %0d want %0d", mul_vs1, t_mul - t_add, gap); end
  endtask

  task automatic test_fill;
    logic [31:0] q[$];
    int j;
    reset_dut;
    for (int i = 0; i < 4; i++) begin
      enq(6, 2'(i), 0, 5'(i + 1), 5'(i + 5), 5'(i + 10));
      q.push_back(word(5'(12 + i), 5'(i + 1), 5'(i + 5), 5'(i + 10)));
    end
    @(negedge clk);
    n_cmp += 2;
    if (fifo_count !== CW'(4)) begin n_bad++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
    if (enq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: enq_ready %b want 0", enq_ready); end
    tick;
    j = 0;
    set_req(6, 0, 0, 20, 0, 1);
    enq_valid = 1'b1;
    tick;
    tick;
    @(negedge clk);
    n_cmp++;
    if (fifo_count !== CW'(4)) begin n_bad++; $display("FAIL fill_held: got %0d want 4", fifo_count); end
    tick;
    instruction_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bit acc, iss;
      @(negedge clk);
      n_cmp += 2;
      if (instruction_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL drain_valid c%0d: got %b want %b", c, instruction_valid, q.size() != 0); end
      if (enq_ready !== (q.size() < DEPTH)) begin n_bad++; $display("FAIL drain_ready c%0d: got %b want %b", c, enq_ready, q.size() < DEPTH); end
      if (q.size() != 0) begin
        n_cmp++;
        if (instruction !== q[0]) begin n_bad++; $display("FAIL drain_order c%0d: got %h want %h", c, instruction, q[0]); end
      end
      iss = q.size() != 0;
      acc = enq_valid && q.size() < DEPTH;
      tick;
      if (iss) void'(q.pop_front());
      if (acc) begin
        q.push_back(word(5'(12 + j % 4), 5'(20 + j), 5'(j), 5'(j + 1)));
        j++;
        if (j < 5) set_req(6, 2'(j % 4), 0, 5'(20 + j), 5'(j), 5'(j + 1));
        else enq_valid = 1'b0;
      end
    end
    n_cmp += 2;
    if (j != 5) begin n_bad++; $display("FAIL fill_refill: accepted %0d want 5", j); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL fill_end_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_illegal;
    reset_dut;
    enq(7, 0, 0, 1, 2, 3);
    @(negedge clk);
    n_cmp += 3;
    if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got %b want 1", illegal); end
    if (illegal_count !== 8'd1) begin n_bad++; $display("FAIL ill_cnt1: got %0d want 1", illegal_count); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL ill_no_enq: got %0d want 0", fifo_count); end
    enq(2, 0, 1, 1, 2, 3);
    @(negedge clk);
    n_cmp += 3;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL ill_pulse_end: got %b want 0", illegal); end
    if (instruction_valid !== 1'b1) begin n_bad++; $display("FAIL vsmul_valid: got %b want 1", instruction_valid); end
    if (instruction !== word(5'b00101, 1, 2, 3)) begin n_bad++; $display("FAIL vsmul_word: got %h want %h", instruction, word(5'b00101, 1, 2, 3)); end
    tick;
    set_req(7, 0, 0, 0, 0, 0);
    enq_valid = 1'b1;
    repeat (300) tick;
    enq_valid = 1'b0;
    tick;
    @(negedge clk);
    n_cmp++;
    if (illegal_count !== 8'd255) begin n_bad++; $display("FAIL ill_saturate: got %0d want 255", illegal_count); end
  endtask

  task automatic test_vstore_flush(input bit do_flush);
    reset_dut;
    instruction_ready = 1'b1;
    enq(1, 0, 0, 9, 1, 2);
    enq(0, 1, 0, 9, 0, 0);
    for (int s = 1; s <= HAZ_LAT; s++) begin
      @(negedge clk);
      n_cmp++;
      if (instruction_valid !== 1'b0) begin n_bad++; $display("FAIL vst_stall%0d: valid %b want 0", s, instruction_valid); end
      tick;
      if (do_flush && s == 2) flush = 1'b1;
    end
    flush = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (instruction_valid !== !do_flush) begin n_bad++; $display("FAIL vst_after%0d: valid %b want %b", do_flush, instruction_valid, !do_flush); end
    if (fifo_count !== CW'(!do_flush)) begin n_bad++; $display("FAIL vst_count%0d: got %0d want %0d", do_flush, fifo_count, !do_flush); end
    if (!do_flush) begin
      n_cmp++;
      if (instruction !== word(5'd1, 9, 0, 0)) begin n_bad++; $display("FAIL vst_word: got %h want %h", instruction, word(5'd1, 9, 0, 0)); end
    end
  endtask

  task automatic test_async_reset;
    reset_dut;
    enq(7, 0, 0, 0, 0, 0);
    enq(1, 0, 0, 3, 1, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp += 5;
    if (instruction_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", instruction_valid); end
    if (instruction !== 32'd0) begin n_bad++; $display("FAIL arst_instr: got %h want 0", instruction); end
    if (fifo_count !== '0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
    if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", enq_ready); end
    if (illegal_count !== 8'd0) begin n_bad++; $display("FAIL arst_ill_cnt: got %0d want 0", illegal_count); end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    bit          have_wr, ipulse, dep, ev, fire, ok;
    int          wr_cyc, icnt;
    logic [4:0]  wr_reg, op;
    logic [31:0] einst, h;
    logic [2:0]  c;
    logic [1:0]  v;
    logic        s;
    have_wr = 0; ipulse = 0; icnt = 0; wr_cyc = 0; wr_reg = '0;
    reset_dut;
    for (int k = 0; k < 600; k++) begin
      do begin
        c = 3'($urandom_range(0, 7));
        v = 2'($urandom_range(0, 3));
        s = $urandom_range(0, 3) == 0;
      end while ((c == 1 && !s && v >= 2) || (c == 4 && v >= 2));
      set_req(c, v, s, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      enq_valid = $urandom_range(0, 9) < 7;
      instruction_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) < 3;
      h = q.size() != 0 ? q[0] : 32'd0;
      dep = have_wr && (k - wr_cyc) <= HAZ_LAT &&
            (h[20:16] == wr_reg || h[15:11] == wr_reg || (h[31:27] == 5'd1 && h[25:21] == wr_reg));
      ev = q.size() != 0 && !dep;
      einst = ev ? h : 32'd0;
      @(negedge clk);
      n_cmp += 6;
      if (instruction_valid !== ev) begin n_bad++; $display("FAIL rnd_valid k%0d: got %b want %b", k, instruction_valid, ev); end
      if (instruction !== einst) begin n_bad++; $display("FAIL rnd_instr k%0d: got %h want %h", k, instruction, einst); end
      if (fifo_count !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_count k%0d: got %0d want %0d", k, fifo_count, q.size()); end
      if (enq_ready !== (q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_ready k%0d: got %b want %b", k, enq_ready, q.size() < DEPTH); end
      if (illegal !== ipulse) begin n_bad++; $display("FAIL rnd_illegal k%0d: got %b want %b", k, illegal, ipulse); end
      if (illegal_count !== 8'(icnt)) begin n_bad++; $display("FAIL rnd_ill_cnt k%0d: got %0d want %0d", k, illegal_count, icnt); end
      fire = enq_valid && q.size() < DEPTH;
      {ok, op} = ref_enc(c, v, s);
      if (ev && instruction_ready) begin
        void'(q.pop_front());
        if (writer(h[31:27])) begin have_wr = 1; wr_cyc = k; wr_reg = h[25:21]; end
      end
      if (flush) begin q.delete(); have_wr = 0; end
      ipulse = fire && !ok;
      if (ipulse && icnt < 255) icnt++;
      if (fire && ok && !flush) q.push_back(word(op, vd, vs1, vs2));
      tick;
    end
    enq_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset;
    test_vadd;
    test_hazard(5'd3, HAZ_LAT + 1);
    test_hazard(5'd7, 1);
    test_fill;
    test_illegal;
    test_vstore_flush(1'b1);
    test_vstore_flush(1'b0);
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vec_instr_encoder.md
# vec_instr_encoder

Host-side producer for the vector coprocessor's 32-bit instruction stream. It accepts field-level operation requests, encodes them into the instruction word format consumed by the datapath decoder, and buffers them in a small FIFO. It issues them downstream with a valid/ready handshake and stalls read-after-write hazards on the most recently written vector register. It sits between the Wishbone/host command logic and the datapath decoder input.

## Interface
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- HAZ_LAT, 3: stall cycles after issuing a vector-register writer; range 0–15.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO and hazard state.
- enq_valid  in  1  request valid.
- enq_ready  out  1  FIFO can accept (= not full).
- op_class  in  3  operation class:
  - 0 load/store, 1 int add/sub, 2 int mul, 3 fp add/sub,
  - 4 fp mul, 5 bitwise, 6 predicate, 7 illegal.
- op_variant  in  2  sub-operation within the class.
- op_scalar  in  1  scalar-operand form.
- vd, vs1, vs2  in  5 each  destination and source register indices.
- instruction  out  32  encoded word at FIFO head; 0 when instruction_valid is low.
- instruction_valid  out  1  head is issuable.
- instruction_ready  in  1  downstream accepts.
- illegal  out  1  registered one-cycle pulse per rejected request.
- illegal_count  out  8  saturating count of rejected requests.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Word format:
  - [31:27] opcode, [26] 0, [25:21] vd, [20:16] vs1, [15:11] vs2, [10:0] 0.
- Opcode map:
  - Load/store: variant 0 → 00000 VLOAD; variant 1 → 00001 VSTORE.
  - Int add/sub, scalar 0: variant 0 → 00010 VADD; variant 1 → 00011 VSUB.
  - Int add/sub, scalar 1: variant 0 → 00110 VSADD.
  - Int mul: scalar 0 → 00100 VMUL; scalar 1 → 00101 VSMUL.
  - Fp add/sub: variant 0 → 00111 VFADD; variant 1 → 10000 VFSUB.
  - Fp mul: 01000 VFMUL.
  - Bitwise: variant 0/1/2 → 01001/01010/01011 (VAND/VOR/VXOR).
  - Predicate: {011, variant} → 01100–01111 (VSEQ/VSNE/VSGT/VSLT).
- Illegal requests:
  - class 7; scalar=1 outside classes 1–2; class 1 with scalar=1 and variant≠0.
  - Classes 0, 3, 4 with variant ≥2; class 5 with variant 3.
  - Class 4 ignores variant.
  - Illegal requests are accepted (consume the enq handshake) but not enqueued.
  - illegal pulses the next cycle; illegal_count increments, saturating at 255.
- FIFO:
  - Enqueue on enq_valid & enq_ready.
  - Dequeue on instruction_valid & instruction_ready.
  - Enqueue and dequeue in the same cycle are allowed when not full and not empty.
  - When full, enq_ready is low even if a dequeue occurs that cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- Hazard tracker (hz_cnt 4 bits, hz_reg 5 bits):
  - Vector writers are VLOAD, VADD, VSUB, VSADD, VMUL, VSMUL, VFADD, VFSUB, VFMUL, VAND, VOR, VXOR.
  - On issuing a writer: hz_cnt ← HAZ_LAT, hz_reg ← vd. This overrides the decrement and reloads even if hz_cnt was nonzero.
  - Otherwise hz_cnt decrements when nonzero.
  - Stall when hz_cnt≠0 and the head's vs1 or vs2 equals hz_reg; VSTORE also compares vd.
  - Predicate ops and VSTORE never load the tracker.
- instruction_valid = !empty & !stall. instruction is combinational from the head entry, gated to 0 when not valid.
- flush:
  - Empties the FIFO and zeroes hz_cnt.
  - Does not change illegal_count.
  - A same-cycle enqueue is dropped; a same-cycle issue still counts as accepted downstream.

## Timing
- Reset values:
  - FIFO empty, fifo_count 0, enq_ready 1, instruction_valid 0, instruction 0.
  - illegal 0, illegal_count 0, hz_cnt 0, hz_reg 0.
- Latency: an entry enqueued at edge t is visible, and valid if there is no hazard, in cycle t+1.
- A dependent instruction issues no earlier than HAZ_LAT+1 cycles after its producer issued. A non-dependent head issues back-to-back.
- Handshake: once instruction_valid is high, instruction stays stable until accepted, or until flush/reset. A hazard cannot arise on a held head, because the tracker loads only on issue.
- A reset asserted mid-stream clears all state immediately (asynchronously). In-flight entries are lost.

## Test plan
- VADD vd=3 vs1=1 vs2=2, ready=1 → instruction=0x10611000 valid one cycle after enqueue; hz_cnt=3.
- VADD vd=3 then VMUL vd=4 vs1=3 vs2=5, HAZ_LAT=3 → VMUL (0x20832800) issues exactly 4 cycles after VADD with valid low for 3 cycles. Repeat with vs1=7 → VMUL issues back-to-back.
- Fill 4 entries with ready=0 → fifo_count=4, enq_ready=0. A fifth request is held. Raise ready → entries drain in order, one per cycle, with pointers wrapping correctly on refill.
- op_class=7, then class 2 with scalar=1 → the first pulses illegal with illegal_count=1 and no enqueue. The second is VSMUL, opcode 00101.
- VSTORE vd=9 after a writer to v9 → stalled HAZ_LAT cycles. Mid-stall flush → valid 0 and fifo_count 0 the next cycle. 256+ illegal requests → illegal_count saturates at 255.
- Assert reset while valid is held → all outputs take their reset values immediately, before the next clock edge.
